// File: rtl/fta_resp_router_if.sv
// Response type shared by the FTA response path, and the bundle of streams
// between the response router and its consumers.
package fta_pkg;
    typedef struct packed {
        logic         ack;
        logic         stall;
        logic         next;
        logic [3:0]   pri;
        logic [5:0]   cid;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;
endpackage

interface fta_resp_router_if #(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 4
);
    import fta_pkg::*;

    fta_cmd_response128_t                           resp_i;
    fta_cmd_response128_t [CHANNELS-1:0]            resp_o;
    logic [CHANNELS-1:0]                            pop;
    logic [CHANNELS-1:0][$clog2(DEPTH):0]           cnt_o;
    logic [CHANNELS-1:0]                            full_o;
    logic [CHANNELS-1:0]                            ovf_o;
    logic [CHANNELS-1:0]                            ovf_clr;

    // Router side
    modport slave (
        input  resp_i, pop, ovf_clr,
        output resp_o, cnt_o, full_o, ovf_o
    );

    // Producer / consumer side
    modport master (
        output resp_i, pop, ovf_clr,
        input  resp_o, cnt_o, full_o, ovf_o
    );
endinterface

// File: rtl/fta_resp_router.sv
// Steers the merged response stream to per-channel FIFOs by cid; each
// channel is drained by its own pop strobe and flags overflow stickily.
module fta_resp_router
    import fta_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 4
) (
    input logic              clk,
    input logic              rst,
    fta_resp_router_if.slave bus
);
    localparam int HBIT = $clog2(CHANNELS);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    fta_cmd_response128_t mem [CHANNELS][DEPTH];
    logic [DEPTH-1:0]     vld    [CHANNELS];
    logic [PW-1:0]        rd_ptr [CHANNELS];
    logic [PW-1:0]        wr_ptr [CHANNELS];
    logic [CW-1:0]        cnt    [CHANNELS];
    logic [CHANNELS-1:0]  ovf;

    logic [HBIT-1:0]      dest;
    logic [CHANNELS-1:0]  hit, full, empty, do_push, do_pop, ovf_set;

    assign dest = bus.resp_i.cid[HBIT-1:0];

    // A pop on a full channel frees the slot the incoming push will use.
    always_comb begin
        hit     = '0;
        full    = '0;
        empty   = '0;
        do_push = '0;
        do_pop  = '0;
        ovf_set = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            hit[n]     = bus.resp_i.ack && (dest == HBIT'(n));
            full[n]    = (cnt[n] == CNT_FULL);
            empty[n]   = (cnt[n] == '0);
            do_pop[n]  = bus.pop[n] && !empty[n];
            do_push[n] = hit[n] && (!full[n] || bus.pop[n]);
            ovf_set[n] = hit[n] && full[n] && !bus.pop[n];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (do_push[n])
                mem[n][wr_ptr[n]] <= bus.resp_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                rd_ptr[n] <= '0;
                wr_ptr[n] <= '0;
                cnt[n]    <= '0;
                vld[n]    <= '0;
            end
            ovf <= '0;
        end else begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                if (do_pop[n]) begin
                    rd_ptr[n]              <= rd_ptr[n] + PW'(1);
                    vld[n][rd_ptr[n]]      <= 1'b0;
                end
                if (do_push[n]) begin
                    wr_ptr[n]              <= wr_ptr[n] + PW'(1);
                    vld[n][wr_ptr[n]]      <= 1'b1;
                end
                if (do_push[n] && !do_pop[n])
                    cnt[n] <= cnt[n] + CW'(1);
                else if (do_pop[n] && !do_push[n])
                    cnt[n] <= cnt[n] - CW'(1);
                if (ovf_set[n])
                    ovf[n] <= 1'b1;
                else if (bus.ovf_clr[n])
                    ovf[n] <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.resp_o = '0;
        bus.cnt_o  = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (!empty[n]) begin
                bus.resp_o[n]       = mem[n][rd_ptr[n]];
                bus.resp_o[n].ack   = vld[n][rd_ptr[n]];
                bus.resp_o[n].stall = 1'b0;
                bus.resp_o[n].next  = 1'b0;
            end else begin
                bus.resp_o[n].pri   = 4'hF;
            end
            bus.cnt_o[n] = cnt[n];
        end
    end

    assign bus.full_o = full;
    assign bus.ovf_o  = ovf;

endmodule

// File: tb/tb_fta_resp_router.sv
// Directed bench for fta_resp_router: routing, ordering/wrap, full/overflow,
// pop-while-full, empty-channel corner cases and asynchronous reset.
module tb_fta_resp_router;
    import fta_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fta_resp_router_if #(.CHANNELS(8), .DEPTH(4)) bus ();

    fta_resp_router #(.CHANNELS(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Junk in stall/next/pri/adr makes sure the head forces or passes them correctly.
    task automatic send(input int cid, input logic [127:0] d, input int tid);
        bus.resp_i       = '0;
        bus.resp_i.ack   = 1'b1;
        bus.resp_i.stall = 1'b1;
        bus.resp_i.next  = 1'b1;
        bus.resp_i.pri   = 4'h3;
        bus.resp_i.cid   = 6'(cid);
        bus.resp_i.tid   = 8'(tid);
        bus.resp_i.adr   = 32'hDEAD_0000 + 32'(cid);
        bus.resp_i.dat   = d;
    endtask

    task automatic idle();
        bus.resp_i = '0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.resp_i  = '0;
        bus.pop     = '0;
        bus.ovf_clr = '0;
        #12;
        check("rst_ack0",  128'(bus.resp_o[0].ack), 128'd0);
        check("rst_pri0",  128'(bus.resp_o[0].pri), 128'hF);
        check("rst_cnt",   128'(bus.cnt_o),  128'd0);
        check("rst_full",  128'(bus.full_o), 128'd0);
        check("rst_ovf",   128'(bus.ovf_o),  128'd0);
        rst = 1'b0;
        tick();

        // Single route
        send(5, 128'hA5A5, 3);
        #1;
        check("no_fallthru", 128'(bus.resp_o[5].ack), 128'd0);
        tick();
        idle();
        check("r5_ack",   128'(bus.resp_o[5].ack),   128'd1);
        check("r5_dat",   bus.resp_o[5].dat,         128'hA5A5);
        check("r5_tid",   128'(bus.resp_o[5].tid),   128'd3);
        check("r5_stall", 128'(bus.resp_o[5].stall), 128'd0);
        check("r5_next",  128'(bus.resp_o[5].next),  128'd0);
        check("r5_pri",   128'(bus.resp_o[5].pri),   128'd3);
        check("r4_idle",  128'(bus.resp_o[4].ack),   128'd0);
        check("r4_pri",   128'(bus.resp_o[4].pri),   128'hF);
        check("r5_cnt",   128'(bus.cnt_o[5]),        128'd1);
        // ack low with otherwise valid fields must not push
        send(5, 128'h77, 9);
        bus.resp_i.ack = 1'b0;
        bus.pop[5] = 1'b1;
        tick();
        bus.pop[5] = 1'b0;
        idle();
        check("r5_popped", 128'(bus.resp_o[5].ack), 128'd0);
        check("r5_pri_idle", 128'(bus.resp_o[5].pri), 128'hF);
        check("r5_cnt0",  128'(bus.cnt_o[5]), 128'd0);

        // Order and wrap with pop held high; push onto empty with pop gives cnt 1
        bus.pop[2] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(2, 128'(i), i);
            tick();
            idle();
            check("ord_dat", bus.resp_o[2].dat, 128'(i));
            check("ord_cnt", 128'(bus.cnt_o[2]), 128'd1);
            tick();
        end
        bus.pop[2] = 1'b0;
        check("ord_empty", 128'(bus.cnt_o[2]), 128'd0);
        check("ord_ovf",   128'(bus.ovf_o[2]), 128'd0);

        // Full and overflow
        for (int i = 1; i <= 5; i++) begin
            send(1, 128'(i), 0);
            tick();
            if (i == 4) begin
                check("full_cnt", 128'(bus.cnt_o[1]),  128'd4);
                check("full_flag", 128'(bus.full_o[1]), 128'd1);
                check("full_ovf0", 128'(bus.ovf_o[1]), 128'd0);
            end
        end
        idle();
        check("ovf_cnt", 128'(bus.cnt_o[1]), 128'd4);
        check("ovf_set", 128'(bus.ovf_o[1]), 128'd1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_dat", bus.resp_o[1].dat, 128'(i));
            bus.pop[1] = 1'b1;
            tick();
            bus.pop[1] = 1'b0;
        end
        check("drain_empty", 128'(bus.cnt_o[1]), 128'd0);
        check("ovf_sticky",  128'(bus.ovf_o[1]), 128'd1);
        bus.ovf_clr[1] = 1'b1;
        tick();
        bus.ovf_clr[1] = 1'b0;
        check("ovf_clr", 128'(bus.ovf_o[1]), 128'd0);

        // Full channel with simultaneous pop; cid 8 maps to channel 0
        for (int i = 11; i <= 14; i++) begin
            send(0, 128'(i), 0);
            tick();
        end
        send(8, 128'd15, 0);
        bus.pop[0] = 1'b1;
        tick();
        bus.pop[0] = 1'b0;
        idle();
        check("fp_cnt", 128'(bus.cnt_o[0]), 128'd4);
        check("fp_ovf", 128'(bus.ovf_o[0]), 128'd0);
        for (int i = 12; i <= 15; i++) begin
            check("fp_dat", bus.resp_o[0].dat, 128'(i));
            if (i == 15) check("fp_cid", 128'(bus.resp_o[0].cid), 128'd8);
            bus.pop[0] = 1'b1;
            tick();
            bus.pop[0] = 1'b0;
        end
        check("fp_empty", 128'(bus.cnt_o[0]), 128'd0);

        // Pop on empty channel is ignored
        bus.pop[3] = 1'b1;
        tick();
        bus.pop[3] = 1'b0;
        check("uf_cnt", 128'(bus.cnt_o[3]), 128'd0);
        check("uf_ack", 128'(bus.resp_o[3].ack), 128'd0);
        send(3, 128'h33, 0);
        tick();
        idle();
        check("uf_push_cnt", 128'(bus.cnt_o[3]), 128'd1);
        check("uf_push_dat", bus.resp_o[3].dat, 128'h33);

        // Overflow and clear in the same cycle: set wins
        for (int i = 1; i <= 4; i++) begin
            send(7, 128'(70 + i), 0);
            tick();
        end
        send(7, 128'd99, 0);
        bus.ovf_clr[7] = 1'b1;
        tick();
        check("sw_set_from0", 128'(bus.ovf_o[7]), 128'd1);
        tick();
        bus.ovf_clr[7] = 1'b0;
        idle();
        check("sw_hold", 128'(bus.ovf_o[7]), 128'd1);
        check("sw_head", bus.resp_o[7].dat, 128'd71);
        bus.ovf_clr[7] = 1'b1;
        tick();
        bus.ovf_clr[7] = 1'b0;
        check("sw_clr", 128'(bus.ovf_o[7]), 128'd0);
        send(7, 128'd98, 0);
        tick();
        idle();
        check("sw_reovf", 128'(bus.ovf_o[7]), 128'd1);

        // Reset mid-operation
        send(4, 128'd41, 0); tick();
        send(4, 128'd42, 0); tick();
        send(6, 128'd61, 0); tick();
        send(6, 128'd62, 0); tick();
        idle();
        check("pre_cnt4", 128'(bus.cnt_o[4]), 128'd2);
        check("pre_cnt6", 128'(bus.cnt_o[6]), 128'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_ack4", 128'(bus.resp_o[4].ack), 128'd0);
        check("ar_pri4", 128'(bus.resp_o[4].pri), 128'hF);
        check("ar_ack6", 128'(bus.resp_o[6].ack), 128'd0);
        check("ar_cnt",  128'(bus.cnt_o),  128'd0);
        check("ar_full", 128'(bus.full_o), 128'd0);
        check("ar_ovf",  128'(bus.ovf_o),  128'd0);
        tick();
        rst = 1'b0;
        send(4, 128'd99, 0);
        tick();
        idle();
        check("post_dat", bus.resp_o[4].dat, 128'd99);
        check("post_cnt", 128'(bus.cnt_o[4]), 128'd1);
        check("post_cnt6", 128'(bus.cnt_o[6]), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
